// File: rtl/mesh_pkg.sv
// Shared mesh router types, field widths and packet field offsets.
package mesh_pkg;

  localparam int unsigned NXT_W = 8;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } dir_e;

  // Field MSB positions as a function of the total packet width w.
  function automatic int unsigned NXT_MSB(input int unsigned w);
    return w - 1;
  endfunction

  function automatic int unsigned ROW_MSB(input int unsigned w);
    return w - 9;
  endfunction

  function automatic int unsigned COL_MSB(input int unsigned w);
    return w - 13;
  endfunction

  function automatic int unsigned MODE_BIT(input int unsigned w);
    return w - 17;
  endfunction

  function automatic int unsigned SRC_MSB(input int unsigned w);
    return w - 18;
  endfunction

  function automatic int unsigned ID_MSB(input int unsigned w);
    return w - 22;
  endfunction

endpackage

// File: rtl/mesh_route_calc.sv
// Next-hop direction from target coordinates, routing mode and router position.
module mesh_route_calc
  import mesh_pkg::*;
(
  input  logic [ROW_W-1:0] tgt_row,
  input  logic [COL_W-1:0] tgt_col,
  input  logic             mode,
  input  logic [ROW_W-1:0] row_id,
  input  logic [COL_W-1:0] col_id,
  output dir_e             dir_c
);

  dir_e vert_c;
  dir_e horz_c;

  // mode=1 resolves the row first, mode=0 resolves the column first
  always_comb begin
    vert_c = SOUTH;
    horz_c = EAST;
    dir_c  = LOCAL;
    if (tgt_row < row_id) vert_c = NORTH;
    if (tgt_col < col_id) horz_c = WEST;
    if ((tgt_row == row_id) && (tgt_col == col_id)) begin
      dir_c = LOCAL;
    end else if (mode) begin
      dir_c = (tgt_row != row_id) ? vert_c : horz_c;
    end else begin
      dir_c = (tgt_col != col_id) ? horz_c : vert_c;
    end
  end

endmodule

// File: rtl/mesh_route_buffer.sv
// Input FIFO and route stage for one mesh router port.
module mesh_route_buffer
  import mesh_pkg::*;
#(
  parameter int unsigned PCKG_SZ = 50,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLUMNS = 4,
  parameter int unsigned ROW_ID  = 1,
  parameter int unsigned COL_ID  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PCKG_SZ-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PCKG_SZ-1:0]       out_data,
  output logic [2:0]               out_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     illegal,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BODY_W = PCKG_SZ - NXT_W;
  localparam int unsigned NXT_HI = NXT_MSB(PCKG_SZ);
  localparam int unsigned ROW_HI = ROW_MSB(PCKG_SZ);
  localparam int unsigned COL_HI = COL_MSB(PCKG_SZ);
  localparam int unsigned MODE_IX = MODE_BIT(PCKG_SZ);
  localparam logic [ROW_W:0] ROWS_LIM = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0] COLS_LIM = (COL_W + 1)'(COLUMNS);

  // Nxt_jump is regenerated on the way out, so only the body is stored
  logic [BODY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  head_idx_c;
  logic [BODY_W-1:0] head_c;
  logic [CNT_W-1:0]  remain_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic              push_c;
  logic              pop_c;
  logic              legal_c;
  logic              wr_en_c;
  logic              unused_nxt_c;
  dir_e              head_dir_c;

  // Handshakes; the head seen at the next edge is the entry after any pop
  always_comb begin
    push_c       = in_valid & in_ready;
    pop_c        = out_valid & out_ready;
    legal_c      = ({1'b0, in_data[ROW_HI -: ROW_W]} < ROWS_LIM) &&
                   ({1'b0, in_data[COL_HI -: COL_W]} < COLS_LIM);
    wr_en_c      = push_c & legal_c;
    remain_c     = count - CNT_W'(pop_c);
    count_nxt_c  = remain_c + CNT_W'(wr_en_c);
    head_idx_c   = rd_ptr + PTR_W'(pop_c);
    head_c       = mem[head_idx_c];
    unused_nxt_c = ^in_data[NXT_HI -: NXT_W];
  end

  mesh_route_calc u_route (
    .tgt_row (head_c[ROW_HI -: ROW_W]),
    .tgt_col (head_c[COL_HI -: COL_W]),
    .mode    (head_c[MODE_IX]),
    .row_id  (ROW_W'(ROW_ID)),
    .col_id  (COL_W'(COL_ID)),
    .dir_c   (head_dir_c)
  );

  // Storage array; stale entries are hidden by the occupancy count
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= in_data[BODY_W-1:0];
  end

  // Pointers, occupancy, registered head presentation and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dir   <= '0;
      illegal   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= head_idx_c;
      count     <= count_nxt_c;
      in_ready  <= (count_nxt_c < CNT_W'(DEPTH));
      out_valid <= (remain_c != '0);
      if (remain_c != '0) begin
        out_data <= {(NXT_W - 3)'(0), head_dir_c, head_c};
        out_dir  <= head_dir_c;
      end
      illegal   <= push_c & ~legal_c;
      overflow  <= in_valid & ~in_ready;
    end
  end

endmodule

// File: tb/tb_mesh_route_buffer.sv
// Directed bench for mesh_route_buffer with a queue-based reference model.
module tb_mesh_route_buffer;

  localparam int W     = 50;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_dir;
  logic         out_valid;
  logic         out_ready;
  logic         illegal;
  logic         overflow;
  logic [3:0]   count;

  int errors = 0;
  int checks = 0;

  mesh_route_buffer #(
    .PCKG_SZ(W), .DEPTH(DEPTH), .ROWS(4), .COLUMNS(4), .ROW_ID(1), .COL_ID(1)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_dir(out_dir),
    .out_valid(out_valid), .out_ready(out_ready), .illegal(illegal),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mkpkt(input int row, input int col, input int mode,
                                         input int src, input int id, input int payload);
    return {8'hA5, 4'(row), 4'(col), 1'(mode), 4'(src), 4'(id), 25'(payload)};
  endfunction

  function automatic int id_of(input logic [W-1:0] d);
    return int'(d[28:25]);
  endfunction

  // Next hop from the rules, via signed offsets from router (1,1)
  function automatic int model_dir(input logic [W-1:0] p);
    int dr, dc;
    dr = int'(p[41:38]) - 1;
    dc = int'(p[37:34]) - 1;
    if (dr == 0 && dc == 0) return 0;
    if (p[33]) begin
      if (dr != 0) return (dr < 0) ? 1 : 2;
      return (dc < 0) ? 4 : 3;
    end
    if (dc != 0) return (dc < 0) ? 4 : 3;
    return (dr < 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of accepted packets plus registered presentation
  logic [W-1:0] q[$];
  logic         m_valid, m_ready, m_ill, m_ovf, m_pop, m_push, m_legal;
  logic [W-1:0] m_data;
  int           m_dir;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_valid = 1'b0; m_ready = 1'b1; m_ill = 1'b0; m_ovf = 1'b0;
      m_data  = '0;   m_dir   = 0;
    end else begin
      m_pop   = m_valid && out_ready;
      m_push  = in_valid && m_ready;
      m_ovf   = in_valid && !m_ready;
      m_legal = (in_data[41:38] < 4) && (in_data[37:34] < 4);
      if (m_pop) void'(q.pop_front());
      m_valid = (q.size() > 0);
      if (m_valid) begin
        m_dir  = model_dir(q[0]);
        m_data = {8'(m_dir), q[0][41:0]};
      end
      if (m_push && m_legal) q.push_back(in_data);
      m_ill   = m_push && !m_legal;
      m_ready = (q.size() < DEPTH);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_in_ready", 64'(in_ready), 64'(m_ready));
      chk("m_out_valid", 64'(out_valid), 64'(m_valid));
      chk("m_illegal", 64'(illegal), 64'(m_ill));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      if (m_valid) begin
        chk("m_out_data", 64'(out_data), 64'(m_data));
        chk("m_out_dir", 64'(out_dir), 64'(m_dir));
      end
    end
  end

  task automatic drain(input string nm, input int n, input int first_id);
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && got < n; c++) begin
      if (out_valid) begin
        chk(nm, 64'(id_of(out_data)), 64'((first_id + got) & 15));
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk({nm, "_n"}, 64'(got), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    int exp_id;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_pulses", 64'({illegal, overflow, out_dir}), 64'd0);
    reset = 1'b0;
    tick();

    // 1: row-first to (3,0) goes south
    p = mkpkt(3, 0, 1, 2, 5, 'hABC);
    in_data = p; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_dir", 64'(out_dir), 64'd2);
    chk("t1_nxt", 64'(out_data[49:42]), 64'h02);
    chk("t1_body", 64'(out_data[41:0]), 64'(p[41:0]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_popped", 64'(out_valid), 64'd0);

    // 2: column-first to (3,0) goes west; (1,1) is local
    in_data = mkpkt(3, 0, 0, 2, 5, 'hABC); in_valid = 1'b1;
    tick();
    in_data = mkpkt(1, 1, 0, 3, 6, 'h123);
    tick();
    in_valid = 1'b0;
    chk("t2_dir_w", 64'(out_dir), 64'd4);
    chk("t2_nxt_w", 64'(out_data[49:42]), 64'h04);
    out_ready = 1'b1;
    tick();
    chk("t2_dir_local", 64'(out_dir), 64'd0);
    chk("t2_nxt_local", 64'(out_data[49:42]), 64'h00);
    chk("t2_id_local", 64'(id_of(out_data)), 64'd6);
    tick();
    out_ready = 1'b0;

    // 3: fill to full, overflow once, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      in_data = mkpkt(2, 2, 1, 1, i, i * 7); in_valid = 1'b1;
      tick();
    end
    in_data = mkpkt(2, 2, 1, 1, 9, 0);
    chk("t3_full_count", 64'(count), 64'd8);
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_count_held", 64'(count), 64'd8);
    tick();
    chk("t3_overflow_once", 64'(overflow), 64'd0);
    drain("t3_drain_id", DEPTH, 0);

    // 4: steady push+pop at occupancy 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      in_data = mkpkt(0, 3, 0, 0, i, i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t4_count_start", 64'(count), 64'd3);
    exp_id = 0;
    for (int k = 0; k < 20; k++) begin
      in_data = mkpkt(k % 4, 3 - (k % 4), k % 2, 0, (3 + k) & 15, k);
      in_valid = 1'b1; out_ready = 1'b1;
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_order", 64'(id_of(out_data)), 64'(exp_id & 15));
      exp_id++;
      tick();
      chk("t4_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    drain("t4_tail", 3, exp_id);

    // 5: illegal row and illegal column are discarded
    in_data = mkpkt(4, 0, 1, 0, 1, 0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_illegal_row", 64'(illegal), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    tick();
    chk("t5_pulse_once", 64'(illegal), 64'd0);
    chk("t5_no_out", 64'(out_valid), 64'd0);
    in_data = mkpkt(0, 4, 0, 0, 2, 0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_illegal_col", 64'(illegal), 64'd1);
    tick();

    // 6: asynchronous reset mid-transfer, then a fresh packet
    for (int i = 0; i < 5; i++) begin
      in_data = mkpkt(1, 2, 0, 0, i, 0); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t6_pre_count", 64'(count), 64'd5);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0; out_ready = 1'b0;
    in_data = mkpkt(2, 1, 0, 0, 11, 'h55); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_fresh_wait", 64'(out_valid), 64'd0);
    tick();
    chk("t6_fresh_valid", 64'(out_valid), 64'd1);
    chk("t6_fresh_id", 64'(id_of(out_data)), 64'd11);
    chk("t6_fresh_dir", 64'(out_dir), 64'd2);
    drain("t6_drain", 1, 11);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
